// File: rtl/qerv_mem_if.sv
// Data-bus front end for qerv: wishbone load/store handshake, load strobe to
// the buffer stage, and rd write-back gating with zero/sign extension.
module qerv_mem_if #(
   parameter int BITS_PER_CYCLE = 4,
   parameter int LB             = $clog2(BITS_PER_CYCLE)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_req,
   input  logic                      i_we,
   input  logic                      i_word,
   input  logic                      i_half,
   input  logic                      i_signed,
   input  logic [31:0]               i_adr,
   input  logic [31:0]               i_wdat,
   output logic                      o_wb_cyc,
   output logic                      o_wb_we,
   output logic [31:0]               o_wb_adr,
   output logic [31:0]               o_wb_dat,
   output logic [3:0]                o_wb_sel,
   input  logic [31:0]               i_wb_rdt,
   input  logic                      i_wb_ack,
   output logic                      o_load,
   output logic [31:0]               o_ldat,
   output logic                      o_ack,
   output logic                      o_misalign,
   output logic                      o_busy,
   input  logic                      i_en,
   input  logic [4:0]                i_cnt,
   input  logic [BITS_PER_CYCLE-1:0] i_q,
   output logic                      o_byte_valid,
   output logic [BITS_PER_CYCLE-1:0] o_rd
);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;

   state_t      state_q, state_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic        ack_q, ack_d;
   logic        mis_q, mis_d;
   logic        sign_q, sign_d;

   logic        misaligned;
   logic [3:0]  sel_req;
   logic [1:0]  bytecnt;
   logic        unused_ok;

   assign misaligned = (i_word & (i_adr[1:0] != 2'b00)) | (i_half & i_adr[0]);
   assign sel_req    = i_word ? 4'b1111 :
                       i_half ? (4'b0011 << i_adr[1:0]) : (4'b0001 << i_adr[1:0]);

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      ack_d   = 1'b0;
      mis_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req) begin
               if (misaligned) begin
                  mis_d = 1'b1;
               end else begin
                  adr_d   = {i_adr[31:2], 2'b00};
                  we_d    = i_we;
                  dat_d   = i_wdat;
                  sel_d   = sel_req;
                  cyc_d   = 1'b1;
                  state_d = WAIT_ACK;
               end
            end
         end
         WAIT_ACK: begin
            if (i_wb_ack) begin
               cyc_d   = 1'b0;
               ack_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= 32'h0;
         dat_q   <= 32'h0;
         sel_q   <= 4'h0;
         ack_q   <= 1'b0;
         mis_q   <= 1'b0;
         sign_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         ack_q   <= ack_d;
         mis_q   <= mis_d;
         sign_q  <= sign_d;
      end
   end

   // Combinational so the buffer stage captures o_ldat on the ack edge itself.
   assign o_load     = i_wb_ack & (state_q == WAIT_ACK) & ~we_q;
   assign o_ldat     = i_wb_rdt;
   assign o_wb_cyc   = cyc_q;
   assign o_wb_we    = we_q;
   assign o_wb_adr   = adr_q;
   assign o_wb_dat   = dat_q;
   assign o_wb_sel   = sel_q;
   assign o_ack      = ack_q;
   assign o_misalign = mis_q;
   assign o_busy     = (state_q != IDLE);

   // Bytes past the access size are replaced by the sign (or zero) fill.
   assign bytecnt      = i_cnt[4:3];
   assign o_byte_valid = i_word | (bytecnt == 2'd0) | (i_half & (bytecnt == 2'd1));
   assign o_rd         = o_byte_valid ? i_q : {BITS_PER_CYCLE{i_signed & sign_q}};
   assign sign_d       = (i_en & o_byte_valid) ? i_q[BITS_PER_CYCLE-1] : sign_q;

   assign unused_ok = &{1'b0, i_cnt[2:0]} | (LB < 0);

endmodule

// File: tb/tb_qerv_mem_if.sv
// Randomized self-checking bench for qerv_mem_if against a size/extension model.
module tb_qerv_mem_if;
   localparam int BPC = 4;

   logic i_clk, i_rst, i_req, i_we, i_word, i_half, i_signed;
   logic [31:0] i_adr, i_wdat, i_wb_rdt;
   logic o_wb_cyc, o_wb_we, i_wb_ack, o_load, o_ack, o_misalign, o_busy, i_en, o_byte_valid;
   logic [31:0] o_wb_adr, o_wb_dat, o_ldat;
   logic [3:0] o_wb_sel;
   logic [4:0] i_cnt;
   logic [BPC-1:0] i_q, o_rd;

   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] last_adr;
   logic [3:0]  last_sel;

   qerv_mem_if #(.BITS_PER_CYCLE(BPC)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_word(i_word),
      .i_half(i_half), .i_signed(i_signed), .i_adr(i_adr), .i_wdat(i_wdat),
      .o_wb_cyc(o_wb_cyc), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat),
      .o_wb_sel(o_wb_sel), .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .o_load(o_load),
      .o_ldat(o_ldat), .o_ack(o_ack), .o_misalign(o_misalign), .o_busy(o_busy),
      .i_en(i_en), .i_cnt(i_cnt), .i_q(i_q), .o_byte_valid(o_byte_valid), .o_rd(o_rd)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic test_reset();
      n_checks++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL rst_cyc got=%b want=0", o_wb_cyc); end
      n_checks++; if (o_wb_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%b want=0", o_wb_we); end
      n_checks++; if (o_wb_adr !== 32'h0) begin n_fail++; $display("FAIL rst_adr got=%h want=0", o_wb_adr); end
      n_checks++; if (o_wb_dat !== 32'h0) begin n_fail++; $display("FAIL rst_dat got=%h want=0", o_wb_dat); end
      n_checks++; if (o_wb_sel !== 4'h0) begin n_fail++; $display("FAIL rst_sel got=%h want=0", o_wb_sel); end
      n_checks++; if (o_ack !== 1'b0 || o_misalign !== 1'b0 || o_busy !== 1'b0)
         begin n_fail++; $display("FAIL rst_ctl got ack=%b mis=%b busy=%b want 0", o_ack, o_misalign, o_busy); end
      // Sign register reset: a signed fill chunk must read as zero.
      i_signed = 1'b1; i_cnt = 5'd8; i_q = 4'h5; #1;
      n_checks++; if (o_rd !== 4'h0) begin n_fail++; $display("FAIL rst_sign got=%h want=0", o_rd); end
      i_signed = 1'b0; i_cnt = 5'd0;
   endtask

   task automatic do_access(input logic we, input logic word, input logic half,
                            input logic [31:0] adr, input logic [31:0] wdat,
                            input logic [31:0] rdt, input int waits, input logic noise);
      int nb;
      logic [3:0] exp_sel;
      logic [31:0] exp_adr;
      nb = word ? 4 : (half ? 2 : 1);
      exp_sel = 4'(((1 << nb) - 1) << adr[1:0]);
      exp_adr = adr & 32'hFFFF_FFFC;
      @(posedge i_clk); #1;
      i_req = 1'b1; i_we = we; i_word = word; i_half = half; i_adr = adr; i_wdat = wdat;
      @(posedge i_clk); #1;
      i_req = 1'b0;
      i_we = 1'($urandom); i_adr = $urandom; i_wdat = $urandom;
      #1;
      n_checks++; if (o_wb_cyc !== 1'b1 || o_busy !== 1'b1) begin n_fail++; $display("FAIL acc_start cyc=%b busy=%b want 1", o_wb_cyc, o_busy); end
      n_checks++; if (o_wb_adr !== exp_adr) begin n_fail++; $display("FAIL acc_adr got=%h want=%h", o_wb_adr, exp_adr); end
      n_checks++; if (o_wb_sel !== exp_sel) begin n_fail++; $display("FAIL acc_sel got=%h want=%h", o_wb_sel, exp_sel); end
      n_checks++; if (o_wb_we !== we) begin n_fail++; $display("FAIL acc_we got=%b want=%b", o_wb_we, we); end
      n_checks++; if (o_wb_dat !== wdat) begin n_fail++; $display("FAIL acc_dat got=%h want=%h", o_wb_dat, wdat); end
      for (int w = 0; w < waits; w++) begin
         @(posedge i_clk); #1;
         if (noise) begin i_req = 1'($urandom); i_word = 1'($urandom); i_adr = $urandom; end
         #1;
         n_checks++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== exp_adr || o_wb_sel !== exp_sel)
            begin n_fail++; $display("FAIL acc_hold cyc=%b adr=%h sel=%h want 1 %h %h", o_wb_cyc, o_wb_adr, o_wb_sel, exp_adr, exp_sel); end
         n_checks++; if (o_load !== 1'b0 || o_ack !== 1'b0 || o_misalign !== 1'b0)
            begin n_fail++; $display("FAIL acc_wait_quiet load=%b ack=%b mis=%b want 0", o_load, o_ack, o_misalign); end
      end
      i_wb_ack = 1'b1; i_wb_rdt = rdt; #1;
      n_checks++; if (o_load !== !we) begin n_fail++; $display("FAIL acc_load got=%b want=%b", o_load, !we); end
      if (!we) begin
         n_checks++; if (o_ldat !== rdt) begin n_fail++; $display("FAIL acc_ldat got=%h want=%h", o_ldat, rdt); end
      end
      @(posedge i_clk); #1;
      i_wb_ack = noise ? 1'($urandom) : 1'b0;
      i_req = noise ? 1'($urandom) : 1'b0;
      #1;
      n_checks++; if (o_ack !== 1'b1 || o_wb_cyc !== 1'b0 || o_load !== 1'b0)
         begin n_fail++; $display("FAIL acc_done ack=%b cyc=%b load=%b want 1 0 0", o_ack, o_wb_cyc, o_load); end
      @(posedge i_clk); #1;
      i_wb_ack = 1'b0; i_req = 1'b0; #1;
      n_checks++; if (o_ack !== 1'b0 || o_busy !== 1'b0 || o_wb_cyc !== 1'b0)
         begin n_fail++; $display("FAIL acc_idle ack=%b busy=%b cyc=%b want 0", o_ack, o_busy, o_wb_cyc); end
      last_adr = exp_adr; last_sel = exp_sel;
   endtask

   task automatic do_misalign(input logic word, input logic half, input logic [31:0] adr);
      @(posedge i_clk); #1;
      i_req = 1'b1; i_word = word; i_half = half; i_adr = adr; i_we = 1'($urandom);
      @(posedge i_clk); #1;
      i_req = 1'b0; #1;
      n_checks++; if (o_misalign !== 1'b1 || o_wb_cyc !== 1'b0 || o_busy !== 1'b0)
         begin n_fail++; $display("FAIL mis_pulse mis=%b cyc=%b busy=%b want 1 0 0", o_misalign, o_wb_cyc, o_busy); end
      n_checks++; if (o_wb_adr !== last_adr || o_wb_sel !== last_sel)
         begin n_fail++; $display("FAIL mis_hold adr=%h sel=%h want %h %h", o_wb_adr, o_wb_sel, last_adr, last_sel); end
      @(posedge i_clk); #2;
      n_checks++; if (o_misalign !== 1'b0 || o_ack !== 1'b0 || o_wb_cyc !== 1'b0)
         begin n_fail++; $display("FAIL mis_after mis=%b ack=%b cyc=%b want 0", o_misalign, o_ack, o_wb_cyc); end
   endtask

   task automatic do_writeback(input logic word, input logic half, input logic sgn, input logic [31:0] v);
      int nbits;
      logic [31:0] expv;
      nbits = word ? 32 : (half ? 16 : 8);
      if (word)      expv = v;
      else if (half) expv = sgn ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
      else           expv = sgn ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
      i_word = word; i_half = half; i_signed = sgn; i_en = 1'b1;
      for (int c = 0; c < 32; c += BPC) begin
         @(posedge i_clk); #1;
         i_cnt = 5'(c); i_q = v[c +: BPC]; #1;
         n_checks++; if (o_byte_valid !== (c < nbits))
            begin n_fail++; $display("FAIL wb_valid cnt=%0d got=%b want=%b", c, o_byte_valid, (c < nbits)); end
         n_checks++; if (o_rd !== expv[c +: BPC])
            begin n_fail++; $display("FAIL wb_rd cnt=%0d got=%h want=%h", c, o_rd, expv[c +: BPC]); end
      end
      @(posedge i_clk); #1;
      i_en = 1'b0; i_cnt = 5'd0;
   endtask

   task automatic test_directed();
      do_access(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0);
      do_access(1'b1, 1'b0, 1'b0, 32'h203, 32'hAA000000, 32'h12345678, 1, 1'b0);
      do_access(1'b0, 1'b0, 1'b1, 32'h102, 32'h0, 32'hCAFE0000, 0, 1'b0);
      do_writeback(1'b0, 1'b0, 1'b1, {$urandom_range(0, 32'hFFFFFF), 8'h80} );
      do_writeback(1'b0, 1'b0, 1'b0, {24'hABCDE1, 8'h80});
      do_writeback(1'b0, 1'b1, 1'b1, 32'h12349876);
      do_misalign(1'b1, 1'b0, 32'h101);
      do_misalign(1'b0, 1'b1, 32'h103);
   endtask

   task automatic test_reset_mid_access();
      @(posedge i_clk); #1;
      i_req = 1'b1; i_we = 1'b0; i_word = 1'b1; i_half = 1'b0; i_adr = 32'h400;
      @(posedge i_clk); #1;
      i_req = 1'b0; #1;
      n_checks++; if (o_wb_cyc !== 1'b1) begin n_fail++; $display("FAIL rma_cyc got=%b want=1", o_wb_cyc); end
      i_rst = 1'b1; #1;
      n_checks++; if (o_wb_cyc !== 1'b0 || o_busy !== 1'b0)
         begin n_fail++; $display("FAIL rma_drop cyc=%b busy=%b want 0", o_wb_cyc, o_busy); end
      @(posedge i_clk); #1;
      i_rst = 1'b0; i_wb_ack = 1'b1; i_wb_rdt = 32'h55AA55AA; #1;
      n_checks++; if (o_load !== 1'b0) begin n_fail++; $display("FAIL rma_load got=%b want=0", o_load); end
      @(posedge i_clk); #1;
      i_wb_ack = 1'b0; #1;
      n_checks++; if (o_ack !== 1'b0 || o_busy !== 1'b0)
         begin n_fail++; $display("FAIL rma_ack ack=%b busy=%b want 0", o_ack, o_busy); end
      last_adr = 32'h0; last_sel = 4'h0;
      do_access(1'b0, 1'b1, 1'b0, 32'h404, 32'h0, 32'h0BADF00D, 0, 1'b0);
   endtask

   task automatic test_random();
      logic word, half;
      logic [31:0] adr;
      for (int n = 0; n < 40; n++) begin
         word = 1'($urandom); half = word ? 1'b0 : 1'($urandom);
         adr = $urandom;
         if ($urandom_range(0, 4) == 0) begin
            if (word) adr[1:0] = 2'($urandom_range(1, 3));
            else begin half = 1'b1; adr[0] = 1'b1; end
            do_misalign(word, half, adr);
         end else begin
            if (word) adr[1:0] = 2'b00;
            else if (half) adr[0] = 1'b0;
            do_access(1'($urandom), word, half, adr, $urandom, $urandom, $urandom_range(0, 3), 1'b1);
            if (n % 4 == 0) do_writeback(word, half, 1'($urandom), $urandom);
         end
      end
   endtask

   initial begin
      i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_word = 1'b0; i_half = 1'b0; i_signed = 1'b0;
      i_adr = 32'h0; i_wdat = 32'h0; i_wb_rdt = 32'h0; i_wb_ack = 1'b0;
      i_en = 1'b0; i_cnt = 5'd0; i_q = '0;
      last_adr = 32'h0; last_sel = 4'h0;
      #12;
      test_reset();
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      test_directed();
      test_reset_mid_access();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
